// File: rtl/button_debouncer.sv
// Front-panel button conditioner: synchronises a raw button, filters bounce,
// and produces a debounced level, press/release strobes, a long-press flag
// and an auto-repeat strobe for the setting keys.
module button_debouncer #(
  parameter int STABLE_CYCLES = 4,   // equal synced samples needed to accept a change
  parameter int HOLD_CYCLES   = 16,  // cycles in PRESSED before long-press
  parameter int REPEAT_CYCLES = 8,   // auto-repeat period while held
  parameter int CNT_W         = 8    // wide enough for the largest of the above
) (
  input  logic clk,
  input  logic reset,
  input  logic in_btn,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o,
  output logic rep_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DB_DN   = 3'd1,
    PRESSED = 3'd2,
    HELD    = 3'd3,
    DB_UP   = 3'd4
  } state_t;

  // Terminal counts: each counter stops at its compare, so none can wrap.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  // A single-sample filter accepts a change on the first differing sample.
  localparam bit SINGLE_SAMPLE = (STABLE_CYCLES == 1);

  logic syncMetaReg;
  logic syncOutReg;
  logic s;

  state_t stateReg, stateNext;
  logic [CNT_W-1:0] dcntReg, dcntNext;
  logic [CNT_W-1:0] hcntReg, hcntNext;
  logic [CNT_W-1:0] rcntReg, rcntNext;
  logic wasHeldReg, wasHeldNext;

  logic levelNext, pressNext, releaseNext, holdNext, repNext;
  logic goPress, goRelease;

  assign s = syncOutReg;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncMetaReg <= 1'b0;
      syncOutReg  <= 1'b0;
    end else begin
      syncMetaReg <= in_btn;
      syncOutReg  <= syncMetaReg;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      dcntReg    <= '0;
      hcntReg    <= '0;
      rcntReg    <= '0;
      wasHeldReg <= 1'b0;
      level_o    <= 1'b0;
      press_o    <= 1'b0;
      release_o  <= 1'b0;
      hold_o     <= 1'b0;
      rep_o      <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      dcntReg    <= dcntNext;
      hcntReg    <= hcntNext;
      rcntReg    <= rcntNext;
      wasHeldReg <= wasHeldNext;
      level_o    <= levelNext;
      press_o    <= pressNext;
      release_o  <= releaseNext;
      hold_o     <= holdNext;
      rep_o      <= repNext;
    end
  end

  // Next-state and next-output logic; strobes default low, levels hold.
  always_comb begin
    stateNext   = stateReg;
    dcntNext    = dcntReg;
    hcntNext    = hcntReg;
    rcntNext    = rcntReg;
    wasHeldNext = wasHeldReg;
    levelNext   = level_o;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    holdNext    = hold_o;
    repNext     = 1'b0;
    goPress     = 1'b0;
    goRelease   = 1'b0;

    case (stateReg)
      IDLE: begin
        levelNext = 1'b0;
        if (s) begin
          if (SINGLE_SAMPLE) begin
            goPress = 1'b1;
          end else begin
            stateNext = DB_DN;
            dcntNext  = CNT_ONE;
          end
        end
      end

      DB_DN: begin
        if (!s) begin
          stateNext = IDLE;
          dcntNext  = '0;
        end else if (dcntReg == STABLE_LAST) begin
          goPress = 1'b1;
        end else begin
          dcntNext = dcntReg + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!s) begin
          if (SINGLE_SAMPLE) begin
            goRelease = 1'b1;
          end else begin
            stateNext   = DB_UP;
            dcntNext    = CNT_ONE;
            wasHeldNext = 1'b0;
          end
        end else if (hcntReg == HOLD_LAST) begin
          stateNext = HELD;
          holdNext  = 1'b1;
          repNext   = 1'b1;  // first repeat coincides with hold rising
          rcntNext  = '0;
        end else begin
          hcntNext = hcntReg + CNT_ONE;
        end
      end

      HELD: begin
        if (!s) begin
          if (SINGLE_SAMPLE) begin
            goRelease = 1'b1;
          end else begin
            stateNext   = DB_UP;
            dcntNext    = CNT_ONE;
            wasHeldNext = 1'b1;
          end
        end else if (rcntReg == REPEAT_LAST) begin
          repNext  = 1'b1;
          rcntNext = '0;
        end else begin
          rcntNext = rcntReg + CNT_ONE;
        end
      end

      DB_UP: begin
        // hcnt/rcnt are left untouched here so a bounce resumes the cadence.
        if (s) begin
          stateNext = wasHeldReg ? HELD : PRESSED;
          dcntNext  = '0;
        end else if (dcntReg == STABLE_LAST) begin
          goRelease = 1'b1;
        end else begin
          dcntNext = dcntReg + CNT_ONE;
        end
      end

      default: begin
        stateNext = IDLE;
        dcntNext  = '0;
        hcntNext  = '0;
        rcntNext  = '0;
        levelNext = 1'b0;
        holdNext  = 1'b0;
      end
    endcase

    if (goPress) begin
      stateNext = PRESSED;
      levelNext = 1'b1;
      pressNext = 1'b1;
      dcntNext  = '0;
      hcntNext  = '0;
    end

    if (goRelease) begin
      stateNext   = IDLE;
      levelNext   = 1'b0;
      holdNext    = 1'b0;
      releaseNext = 1'b1;
      dcntNext    = '0;
      hcntNext    = '0;
      rcntNext    = '0;
      wasHeldNext = 1'b0;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: a table of per-cycle vectors for the default
// configuration plus a hand-written sequence for a fast configuration.
// Expected outputs are queued when inputs are driven and compared after the edge.
module tb_button_debouncer;

  localparam int LV = 4;  // level_o
  localparam int PR = 3;  // press_o
  localparam int RL = 2;  // release_o
  localparam int HD = 1;  // hold_o
  localparam int RP = 0;  // rep_o

  logic clk = 1'b0;
  logic resetA, btnA, levelA, pressA, releaseA, holdA, repA;
  logic resetB, btnB, levelB, pressB, releaseB, holdB, repB;

  always #5 clk = ~clk;

  button_debouncer dutA (
    .clk       (clk),
    .reset     (resetA),
    .in_btn    (btnA),
    .level_o   (levelA),
    .press_o   (pressA),
    .release_o (releaseA),
    .hold_o    (holdA),
    .rep_o     (repA)
  );

  button_debouncer #(
    .STABLE_CYCLES (1),
    .HOLD_CYCLES   (1),
    .REPEAT_CYCLES (3),
    .CNT_W         (8)
  ) dutB (
    .clk       (clk),
    .reset     (resetB),
    .in_btn    (btnB),
    .level_o   (levelB),
    .press_o   (pressB),
    .release_o (releaseB),
    .hold_o    (holdB),
    .rep_o     (repB)
  );

  typedef struct {
    bit         btn;
    bit         rst;
    logic [4:0] exp;
    int         seg;
  } vec_t;

  typedef struct {
    logic [4:0] exp;
    int         unit;
    int         seg;
    int         idx;
  } sb_t;

  vec_t vecs [0:399];
  int   nVec = 0;
  sb_t  sbQ[$];
  int   checks = 0;
  int   passes = 0;

  function automatic string segName(input int seg);
    case (seg)
      0:       return "reset";
      1:       return "clean_press";
      2:       return "bounce";
      3:       return "long_press";
      4:       return "release_bounce";
      5:       return "reset_mid_held";
      6:       return "fast_params";
      default: return "unknown";
    endcase
  endfunction

  task automatic addVec(input bit btn, input bit rst, input int seg);
    vecs[nVec].btn = btn;
    vecs[nVec].rst = rst;
    vecs[nVec].exp = 5'b0;
    vecs[nVec].seg = seg;
    nVec++;
  endtask

  task automatic mark(input int b, input int from, input int to);
    for (int i = from; i <= to; i++) vecs[i].exp[b] = 1'b1;
  endtask

  task automatic pushExp(input logic [4:0] exp, input int unit, input int seg, input int idx);
    sb_t item;
    item.exp  = exp;
    item.unit = unit;
    item.seg  = seg;
    item.idx  = idx;
    sbQ.push_back(item);
  endtask

  task automatic checkOne(input int unit);
    sb_t item;
    logic [4:0] actual;
    checks++;
    if (sbQ.size() == 0) begin
      $display("FAIL scoreboard_empty: got no queued expectation, required one");
    end else begin
      item = sbQ.pop_front();
      if (unit == 0) actual = {levelA, pressA, releaseA, holdA, repA};
      else           actual = {levelB, pressB, releaseB, holdB, repB};
      if (actual === item.exp) begin
        passes++;
      end else begin
        $display("FAIL %s[%0d]: lvl/prs/rel/hld/rep got %b required %b",
                 segName(item.seg), item.idx, actual, item.exp);
      end
    end
  endtask

  initial begin
    int base;
    resetA = 1'b1;
    btnA   = 1'b0;
    resetB = 1'b1;
    btnB   = 1'b0;

    // Reset state, then a few idle cycles.
    for (int k = 0; k < 6; k++) addVec(1'b0, k < 3, 0);

    // Clean press: 10 cycles high; press 5 edges after first sample.
    base = nVec;
    for (int k = 0; k < 24; k++) addVec(k < 10, 1'b0, 1);
    mark(LV, base + 5, base + 14);
    mark(PR, base + 5, base + 5);
    mark(RL, base + 15, base + 15);

    // Bounce 1,0,1,1,0 then low: nothing accepted.
    base = nVec;
    for (int k = 0; k < 14; k++) addVec((k == 0) || (k == 2) || (k == 3), 1'b0, 2);

    // Long press: 60 cycles high.
    base = nVec;
    for (int k = 0; k < 72; k++) addVec(k < 60, 1'b0, 3);
    mark(LV, base + 5, base + 64);
    mark(PR, base + 5, base + 5);
    mark(HD, base + 21, base + 64);
    mark(RL, base + 65, base + 65);
    for (int t = 21; t <= 61; t += 8) mark(RP, base + t, base + t);

    // Release bounce while held: two low samples, cadence resumes 3 cycles late.
    base = nVec;
    for (int k = 0; k < 62; k++) addVec((k < 50) && (k != 24) && (k != 25), 1'b0, 4);
    mark(LV, base + 5, base + 54);
    mark(PR, base + 5, base + 5);
    mark(HD, base + 21, base + 54);
    mark(RL, base + 55, base + 55);
    mark(RP, base + 21, base + 21);
    mark(RP, base + 32, base + 32);
    mark(RP, base + 40, base + 40);
    mark(RP, base + 48, base + 48);

    // Reset for one cycle while held with the button still down.
    base = nVec;
    for (int k = 0; k < 52; k++) addVec(k < 40, k == 30, 5);
    mark(LV, base + 5, base + 29);
    mark(PR, base + 5, base + 5);
    mark(HD, base + 21, base + 29);
    mark(RP, base + 21, base + 21);
    mark(RP, base + 29, base + 29);
    mark(LV, base + 36, base + 44);
    mark(PR, base + 36, base + 36);
    mark(RL, base + 45, base + 45);

    // Apply the table to the default-parameter instance.
    for (int i = 0; i < nVec; i++) begin
      btnA   = vecs[i].btn;
      resetA = vecs[i].rst;
      pushExp(vecs[i].exp, 0, vecs[i].seg, i);
      @(posedge clk);
      #1;
      checkOne(0);
    end

    // Fast instance (STABLE=1, HOLD=1, REPEAT=3): press, immediate hold, release.
    for (int k = 0; k < 18; k++) begin
      int j;
      logic [4:0] e;
      j = k - 2;
      e = 5'b0;
      resetB = (k < 2);
      btnB   = (k >= 2) && (j < 8);
      if (k >= 2) begin
        e[LV] = (j >= 2) && (j <= 9);
        e[PR] = (j == 2);
        e[HD] = (j >= 3) && (j <= 9);
        e[RP] = (j == 3) || (j == 6) || (j == 9);
        e[RL] = (j == 10);
      end
      pushExp(e, 1, 6, k);
      @(posedge clk);
      #1;
      checkOne(1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
